// File: rtl/traffic_light_ctrl_param.sv
// Two-road (main/cross) intersection controller.
// Moore FSM with a shared phase timer, all-red clearance, a latched cross
// request honoured only after a minimum main green, optional free-running
// cycling, and a flashing fail-safe mode. Lamp encoding is {red,yellow,green}.
// Handshake note: there is no valid/ready traffic here; cross_req and flash_en
// are plain levels sampled on every rising clock edge.
module traffic_light_ctrl_param #(
  parameter int TIMER_W          = 8,
  parameter int MAIN_GREEN_MIN   = 8,
  parameter int CROSS_GREEN_TIME = 6,
  parameter int YELLOW_TIME      = 3,
  parameter int ALL_RED_TIME     = 2,
  parameter int FLASH_HALF       = 4,
  parameter int AUTO_CYCLE       = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cross_req,
  input  logic       flash_en,
  output logic [2:0] main_light,
  output logic [2:0] cross_light,
  output logic       walk,
  output logic       req_pending,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_MAIN_GREEN   = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW  = 3'd1;
  localparam logic [2:0] S_ALL_RED_A    = 3'd2;
  localparam logic [2:0] S_CROSS_GREEN  = 3'd3;
  localparam logic [2:0] S_CROSS_YELLOW = 3'd4;
  localparam logic [2:0] S_ALL_RED_B    = 3'd5;
  localparam logic [2:0] S_FLASH        = 3'd6;

  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_DARK   = 3'b000;

  // Reload values are T-1 so that a phase of length T lasts exactly T cycles.
  localparam logic [TIMER_W-1:0] MG_LOAD = TIMER_W'(MAIN_GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] CG_LOAD = TIMER_W'(CROSS_GREEN_TIME - 1);
  localparam logic [TIMER_W-1:0] Y_LOAD  = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_LOAD = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [TIMER_W-1:0] FH_LOAD = TIMER_W'(FLASH_HALF - 1);
  localparam logic [TIMER_W-1:0] ONE     = TIMER_W'(1);
  localparam logic               AUTO    = (AUTO_CYCLE != 0);

  logic [2:0]         state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               req_latch, req_next;
  logic               blink, blink_next;
  logic               timer_done;

  assign timer_done = (timer == '0);

  // State, phase timer, request latch and blink phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_MAIN_GREEN;
      timer     <= MG_LOAD;
      req_latch <= 1'b0;
      blink     <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      req_latch <= req_next;
      blink     <= blink_next;
    end
  end

  // Next-state decision; yellow and all-red phases ignore flash_en until they expire.
  always_comb begin
    state_next = state;
    case (state)
      S_MAIN_GREEN:
        if (flash_en || (timer_done && (req_latch || AUTO))) state_next = S_MAIN_YELLOW;
      S_MAIN_YELLOW:
        if (timer_done) state_next = S_ALL_RED_A;
      S_ALL_RED_A:
        if (timer_done) state_next = flash_en ? S_FLASH : S_CROSS_GREEN;
      S_CROSS_GREEN:
        if (flash_en || timer_done) state_next = S_CROSS_YELLOW;
      S_CROSS_YELLOW:
        if (timer_done) state_next = S_ALL_RED_B;
      S_ALL_RED_B:
        if (timer_done) state_next = flash_en ? S_FLASH : S_MAIN_GREEN;
      S_FLASH:
        if (!flash_en) state_next = S_ALL_RED_B;
      default:
        state_next = S_ALL_RED_B;
    endcase
  end

  // Timer reload on phase entry, countdown otherwise; in FLASH the timer paces the blink.
  always_comb begin
    timer_next = timer;
    blink_next = blink;
    if (state_next != state) begin
      case (state_next)
        S_MAIN_GREEN:   timer_next = MG_LOAD;
        S_MAIN_YELLOW:  timer_next = Y_LOAD;
        S_CROSS_YELLOW: timer_next = Y_LOAD;
        S_CROSS_GREEN:  timer_next = CG_LOAD;
        S_FLASH:        timer_next = FH_LOAD;
        default:        timer_next = AR_LOAD;
      endcase
      blink_next = (state_next == S_FLASH);
    end else if (state == S_FLASH) begin
      if (timer_done) begin
        timer_next = FH_LOAD;
        blink_next = ~blink;
      end else begin
        timer_next = timer - ONE;
      end
    end else if (!timer_done) begin
      timer_next = timer - ONE;
    end
  end

  // Request latch: cleared on cross-green entry (wins over a set), requests during cross green dropped.
  always_comb begin
    req_next = req_latch;
    if ((state_next == S_CROSS_GREEN) && (state != S_CROSS_GREEN)) req_next = 1'b0;
    else if (cross_req && (state != S_CROSS_GREEN)) req_next = 1'b1;
  end

  // Lamp decode from registered state and blink phase; illegal codes show all red.
  always_comb begin
    main_light  = L_RED;
    cross_light = L_RED;
    walk        = 1'b0;
    case (state)
      S_MAIN_GREEN:   main_light = L_GREEN;
      S_MAIN_YELLOW:  main_light = L_YELLOW;
      S_CROSS_GREEN: begin
        cross_light = L_GREEN;
        walk        = 1'b1;
      end
      S_CROSS_YELLOW: cross_light = L_YELLOW;
      S_FLASH: begin
        main_light  = blink ? L_YELLOW : L_DARK;
        cross_light = blink ? L_RED : L_DARK;
      end
      default: begin
        main_light  = L_RED;
        cross_light = L_RED;
      end
    endcase
  end

  assign req_pending = req_latch;
  assign state_dbg   = state;

endmodule
